// File: rtl/spi_xfer_queue_pkg.sv
// Shared definitions for the SPI transfer queue: default sizing and the
// transfer FSM state encoding.
// Ports: none (package).
package spi_xfer_queue_pkg;

   localparam int DATA_W_DEF      = 8;
   localparam int DEPTH_DEF       = 4;
   localparam int TIMEOUT_CYC_DEF = 256;

   // One transfer in flight at most: IDLE picks a byte, LAUNCH pulses start,
   // WAIT watches for done or timeout, STORE writes the reply into RX.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_STORE  = 2'd3
   } xfer_state_t;

endpackage

// File: rtl/spi_xfer_queue_sync_fifo.sv
// Purpose : register-based synchronous FIFO with count-based full/empty.
// Latency : push visible at the head (empty=0) the cycle after the push edge.
// Backpr. : push ignored when full, pop ignored when empty; caller gates on count/empty.
// Ports   : clk, reset (async active-low), push/wdata, pop/rdata, empty, count (0..DEPTH).
module spi_xfer_queue_sync_fifo
   import spi_xfer_queue_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [DATA_W-1:0]      wdata,
   input  logic                   pop,
   output logic [DATA_W-1:0]      rdata,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [CW-1:0]     cnt;
   logic              is_full;
   logic              do_push;
   logic              do_pop;

   assign is_full = (cnt == CW'(DEPTH));
   assign empty   = (cnt == '0);
   assign do_push = push & ~is_full;
   assign do_pop  = pop & ~empty;
   assign count   = cnt;
   // Head reads as zero while empty so the output is clean straight out of reset.
   assign rdata   = empty ? '0 : mem[rd_ptr];

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Storage needs no reset: entries are only read while counted as valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/spi_xfer_queue.sv
// Purpose : TX/RX byte queue in front of an SPI master; launches one transfer at a time, flags lost transfers.
// Latency : TX push edge N -> spi_start in cycle N+2; spi_done cycle M -> rx_valid cycle M+2.
// Backpr. : tx_ready drops when TX full; a full RX FIFO stalls new launches so no reply is ever dropped.
// Ports   : clk, reset (async active-low); tx_data/tx_valid/tx_ready in; rx_data/rx_valid/rx_ready out;
//           spi_start/spi_din/spi_dout/spi_done to the master; busy, tx_level, timeout_err, err_clr status.
module spi_xfer_queue
   import spi_xfer_queue_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int DEPTH       = DEPTH_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [DATA_W-1:0]      tx_data,
   input  logic                   tx_valid,
   output logic                   tx_ready,
   output logic [DATA_W-1:0]      rx_data,
   output logic                   rx_valid,
   input  logic                   rx_ready,
   output logic                   spi_start,
   output logic [DATA_W-1:0]      spi_din,
   input  logic [DATA_W-1:0]      spi_dout,
   input  logic                   spi_done,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] tx_level,
   output logic                   timeout_err,
   input  logic                   err_clr
);

   localparam int                LVL_W    = $clog2(DEPTH) + 1;
   localparam int                CNT_W    = $clog2(TIMEOUT_CYC);
   localparam logic [LVL_W-1:0]  LVL_FULL = LVL_W'(DEPTH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

   xfer_state_t       state_q;
   xfer_state_t       state_d;

   logic [DATA_W-1:0] tx_head;
   logic              tx_empty;
   logic [LVL_W-1:0]  tx_count;
   logic              rx_empty;
   logic [LVL_W-1:0]  rx_count;

   logic [DATA_W-1:0] hold_q;
   logic [CNT_W-1:0]  tmo_cnt;

   logic              tx_pop;
   logic              load_din;
   logic              cnt_clr;
   logic              cnt_inc;
   logic              capture;
   logic              set_err;
   logic              rx_push;

   spi_xfer_queue_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_tx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (tx_valid),
      .wdata (tx_data),
      .pop   (tx_pop),
      .rdata (tx_head),
      .empty (tx_empty),
      .count (tx_count)
   );

   spi_xfer_queue_sync_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_rx_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (rx_push),
      .wdata (hold_q),
      .pop   (rx_ready),
      .rdata (rx_data),
      .empty (rx_empty),
      .count (rx_count)
   );

   assign tx_ready  = (tx_count != LVL_FULL);
   assign tx_level  = tx_count;
   assign rx_valid  = ~rx_empty;
   assign spi_start = (state_q == ST_LAUNCH);
   assign busy      = (state_q != ST_IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      tx_pop   = 1'b0;
      load_din = 1'b0;
      cnt_clr  = 1'b0;
      cnt_inc  = 1'b0;
      capture  = 1'b0;
      set_err  = 1'b0;
      rx_push  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // Only launch when the reply is guaranteed a slot in RX.
            if (!tx_empty && (rx_count != LVL_FULL)) begin
               tx_pop   = 1'b1;
               load_din = 1'b1;
               state_d  = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            cnt_clr = 1'b1;
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // A done arriving on the very last allowed cycle still counts.
            if (spi_done) begin
               capture = 1'b1;
               state_d = ST_STORE;
            end else if (tmo_cnt == CNT_LAST) begin
               set_err = 1'b1;
               state_d = ST_IDLE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         ST_STORE: begin
            rx_push = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         spi_din     <= '0;
         hold_q      <= '0;
         tmo_cnt     <= '0;
         timeout_err <= 1'b0;
      end else begin
         // spi_din holds the launched byte until the next launch.
         if (load_din) spi_din <= tx_head;
         if (capture)  hold_q  <= spi_dout;
         if (cnt_clr)      tmo_cnt <= '0;
         else if (cnt_inc) tmo_cnt <= tmo_cnt + CNT_W'(1);
         // A new timeout beats a simultaneous clear so the event is never lost.
         if (set_err)      timeout_err <= 1'b1;
         else if (err_clr) timeout_err <= 1'b0;
      end
   end

endmodule
